// File: rtl/mem_sync_para.sv
`default_nettype none
// ============================================================================
//  Module   : mem_sync_para
//  Purpose  : Single-port synchronous word memory with a hardware clear engine.
//             After reset, or on a clr request, every word is zeroed, one word
//             per cycle. Requests are taken only while ready is high. Reads
//             return registered data one cycle after acceptance. Out-of-range
//             accesses raise a one-cycle err pulse.
//  Ports    : clk      - clock; all state updates on the rising edge
//             rst      - synchronous active-high reset
//             clr      - request a full-memory clear to zero
//             en       - access request, qualified by ready
//             wr       - 1 = write, 0 = read (sampled with en)
//             addr     - word address (ADDR_WIDTH bits)
//             data_in  - write data (DATA_WIDTH bits)
//             ready    - block accepts a request this cycle (IDLE state)
//             data_out - registered read data, held between reads
//             rd_valid - one-cycle pulse: data_out holds new read data
//             err      - one-cycle pulse: last accepted request was out of range
//  Revision : 1.0 - initial release
// ============================================================================
module mem_sync_para #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  err
);

  // Index width: enough bits to address DEPTH words (at least one bit).
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
  // DEPTH may equal 2^ADDR_WIDTH, so compare against it one bit wider.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  accept;

  assign in_range = ({1'b0, addr} < DEPTH_EXT);
  assign idx      = addr[IDX_W-1:0];
  // clr wins over a simultaneous request, so it blocks acceptance.
  assign accept   = (state == S_IDLE) && en && !clr;
  assign ready    = (state == S_IDLE);

  // Control state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      cnt      <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_CLEAR: begin
          if (clr) begin
            cnt <= '0;
          end else if (cnt == LAST_IDX) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (clr) begin
            cnt   <= '0;
            state <= S_CLEAR;
          end else if (accept) begin
            if (!in_range) begin
              err <= 1'b1;
            end else if (!wr) begin
              data_out <= mem[idx];
              rd_valid <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Storage array kept reset-free; the clear engine zeroes it after reset.
  // A clr arriving in CLEAR restarts the sweep rather than writing this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR && !clr) begin
        mem[cnt] <= '0;
      end else if (accept && wr && in_range) begin
        mem[idx] <= data_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_sync_para.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_sync_para
//  Purpose  : Self-checking bench for mem_sync_para. A default instance
//             (DEPTH=8) and a DEPTH=6 instance share all inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sync_para;

  logic       clk = 1'b0;
  logic       rst, clr, en, wr;
  logic [2:0] addr;
  logic [3:0] data_in;

  logic       ready,  rd_valid,  err;
  logic [3:0] data_out;
  logic       ready6, rd_valid6, err6;
  logic [3:0] data_out6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_sync_para dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .wr(wr), .addr(addr),
    .data_in(data_in), .ready(ready), .data_out(data_out),
    .rd_valid(rd_valid), .err(err)
  );

  mem_sync_para #(.ADDR_WIDTH(3), .DATA_WIDTH(4), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .wr(wr), .addr(addr),
    .data_in(data_in), .ready(ready6), .data_out(data_out6),
    .rd_valid(rd_valid6), .err(err6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic c, input logic e, input logic w,
                     input logic [2:0] a, input logic [3:0] d);
    clr = c; en = e; wr = w; addr = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic       wr;
    logic [2:0] addr;
    logic [3:0] din;
    logic       rv;
    logic       er;
    logic [3:0] dout;
  } vec_t;

  vec_t vt [11];

  initial begin
    // Outputs of the DEPTH=8 instance expected after each vector's edge.
    vt[0]  = '{1'b1, 1'b0, 3'd5, 4'h0, 1'b1, 1'b0, 4'h0}; // read cleared word
    vt[1]  = '{1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 4'h0}; // idle: pulse ends
    vt[2]  = '{1'b1, 1'b1, 3'd3, 4'hA, 1'b0, 1'b0, 4'h0}; // write A -> 3
    vt[3]  = '{1'b1, 1'b0, 3'd3, 4'h0, 1'b1, 1'b0, 4'hA}; // read-after-write
    vt[4]  = '{1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 4'hA}; // data_out holds
    vt[5]  = '{1'b1, 1'b1, 3'd0, 4'h7, 1'b0, 1'b0, 4'hA}; // write 7 -> 0
    vt[6]  = '{1'b1, 1'b1, 3'd7, 4'h9, 1'b0, 1'b0, 4'hA}; // write 9 -> 7
    vt[7]  = '{1'b1, 1'b0, 3'd0, 4'h0, 1'b1, 1'b0, 4'h7}; // back-to-back reads
    vt[8]  = '{1'b1, 1'b0, 3'd7, 4'h0, 1'b1, 1'b0, 4'h9};
    vt[9]  = '{1'b1, 1'b0, 3'd3, 4'h0, 1'b1, 1'b0, 4'hA};
    vt[10] = '{1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 4'hA};

    rst = 1'b1; clr = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; data_in = '0;

    // ---------------- reset and release ----------------
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ready",    32'(ready),    32'd0);
    chk("rst_dout",     32'(data_out), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_err",      32'(err),      32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("release_ready",  32'(ready),  32'd0);
      chk("release_ready6", 32'(ready6), (i >= 6) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    chk("release_ready_up", 32'(ready), 32'd1);

    // ---------------- table-driven accesses ----------------
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, vt[i].en, vt[i].wr, vt[i].addr, vt[i].din);
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vt[i].rv));
      chk($sformatf("vec%0d_err", i),      32'(err),      32'(vt[i].er));
      chk($sformatf("vec%0d_dout", i),     32'(data_out), 32'(vt[i].dout));
      chk($sformatf("vec%0d_ready", i),    32'(ready),    32'd1);
    end

    // ---------------- out of range on DEPTH=6 ----------------
    // DEPTH=6 contents now: 0->7, 3->A; the write of 9 to addr 7 was dropped.
    cyc(1'b0, 1'b1, 1'b1, 3'd5, 4'h3);
    cyc(1'b0, 1'b1, 1'b0, 3'd5, 4'h0);
    chk("d6_read5_rv",   32'(rd_valid6), 32'd1);
    chk("d6_read5_dout", 32'(data_out6), 32'h3);
    cyc(1'b0, 1'b1, 1'b0, 3'd7, 4'h0);
    chk("d6_rd7_err",  32'(err6),      32'd1);
    chk("d6_rd7_rv",   32'(rd_valid6), 32'd0);
    chk("d6_rd7_dout", 32'(data_out6), 32'h3);
    cyc(1'b0, 1'b1, 1'b1, 3'd7, 4'hF);
    chk("d6_wr7_err",  32'(err6),      32'd1);
    chk("d6_wr7_rv",   32'(rd_valid6), 32'd0);
    chk("d6_wr7_dout", 32'(data_out6), 32'h3);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("d6_err_pulse_end", 32'(err6), 32'd0);
    begin
      logic [3:0] exp6 [6];
      exp6[0] = 4'h7; exp6[1] = 4'h0; exp6[2] = 4'h0;
      exp6[3] = 4'hA; exp6[4] = 4'h0; exp6[5] = 4'h3;
      for (int a = 0; a < 6; a++) begin
        cyc(1'b0, 1'b1, 1'b0, 3'(a), 4'h0);
        chk($sformatf("d6_mem%0d_rv", a),   32'(rd_valid6), 32'd1);
        chk($sformatf("d6_mem%0d_dout", a), 32'(data_out6), 32'(exp6[a]));
      end
    end
    // Last read of the DEPTH=8 instance was addr 5 = 3.

    // ---------------- full clear with simultaneous en ----------------
    for (int a = 0; a < 8; a++) cyc(1'b0, 1'b1, 1'b1, 3'(a), 4'h5);
    cyc(1'b1, 1'b1, 1'b0, 3'd2, 4'h0);
    chk("clr_en_ignored_rv", 32'(rd_valid), 32'd0);
    chk("clr_dout_kept",     32'(data_out), 32'h3);
    clr = 1'b0; en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("clr_ready_low", 32'(ready), 32'd0);
      chk("clr_rv_low",    32'(rd_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("clr_ready_up", 32'(ready), 32'd1);
    chk("clr_dout_unchanged", 32'(data_out), 32'h3);
    for (int a = 0; a < 8; a++) begin
      cyc(1'b0, 1'b1, 1'b0, 3'(a), 4'h0);
      chk($sformatf("clr_mem%0d_rv", a),   32'(rd_valid), 32'd1);
      chk($sformatf("clr_mem%0d_dout", a), 32'(data_out), 32'h0);
    end

    // ---------------- clr restart at clear count 4 ----------------
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("restart_ready_low", 32'(ready), 32'd0);
      chk("restart_err_low",   32'(err),   32'd0);
      @(posedge clk); #1;
    end
    chk("restart_ready_up", 32'(ready), 32'd1);

    // ---------------- rst during a read acceptance ----------------
    cyc(1'b0, 1'b1, 1'b1, 3'd2, 4'h6);
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 4'h0);
    chk("pre_rst_dout", 32'(data_out), 32'h6);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 4'h0);
    chk("rst_read_rv",    32'(rd_valid), 32'd0);
    chk("rst_read_dout",  32'(data_out), 32'h0);
    chk("rst_read_ready", 32'(ready),    32'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("rst_read_rv_after", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("rst2_ready_low", 32'(ready), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("rst2_ready_up",  32'(ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_sync_para.md
MEM_SYNC_PARA -- requirements
Module: mem_sync_para

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: address bus width in bits.
REQ-002 Parameter DATA_WIDTH, default 4: word width in bits.
REQ-003 Parameter DEPTH, default 8: number of words; legal range 1 to 2^ADDR_WIDTH.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port clr, input, 1: request a full-memory clear to zero.
REQ-008 Port en, input, 1: access request, qualified by ready.
REQ-009 Port wr, input, 1: 1 = write, 0 = read; sampled with en.
REQ-010 Port addr, input, ADDR_WIDTH: word address.
REQ-011 Port data_in, input, DATA_WIDTH: write data.
REQ-012 Port ready, output, 1: block can accept a request this cycle.
REQ-013 Port data_out, output, DATA_WIDTH: registered read data.
REQ-014 Port rd_valid, output, 1: single-cycle pulse; data_out holds new read data.
REQ-015 Port err, output, 1: single-cycle pulse; the previous accepted request was out of range.

Function
REQ-016 The block SHALL have two states, CLEAR and IDLE. ready = 1 only in IDLE.
REQ-017 A request SHALL be accepted when en && ready is 1 at a rising edge. Requests with ready = 0 SHALL be ignored, not queued.
REQ-018 An accepted write with addr < DEPTH SHALL update mem[addr] to data_in at that edge. There is no response pulse.
REQ-019 An accepted read with addr < DEPTH SHALL load data_out with mem[addr] and pulse rd_valid on the next cycle. Latency is 1 cycle.
REQ-020 An accepted request with addr >= DEPTH SHALL leave memory and data_out unchanged, SHALL pulse err on the next cycle, and SHALL NOT pulse rd_valid.
REQ-021 data_out SHALL hold its value between reads.
REQ-022 Back-to-back accepted requests SHALL be supported at one per cycle in IDLE.
REQ-023 Read-after-write to the same address on consecutive cycles SHALL return the newly written data.
REQ-024 In CLEAR, an internal counter SHALL write zero to addresses 0 through DEPTH-1, one per cycle, ascending.
REQ-025 After the write to DEPTH-1, the next state SHALL be IDLE. CLEAR therefore lasts exactly DEPTH cycles.
REQ-026 clr = 1 in IDLE SHALL move to CLEAR with the counter at 0. clr takes priority over a simultaneous en, which is not accepted.
REQ-027 clr = 1 while in CLEAR SHALL restart the counter at 0.
REQ-028 data_out SHALL be unchanged by a clear, and rd_valid and err SHALL be 0 throughout CLEAR.
REQ-029 When addr < DEPTH, only the low ceil(log2(DEPTH)) bits SHALL index memory. No address wrap-around is permitted.

Reset
REQ-030 rst = 1 SHALL force: state CLEAR, counter 0, ready 0, data_out 0, rd_valid 0, err 0. rst has priority over every other input.
REQ-031 After rst is released, the block SHALL complete a full clear: ready rises DEPTH cycles after the first cycle with rst = 0.
REQ-032 rst asserted mid-clear or mid-access SHALL abandon the operation and restart per REQ-030. A pending rd_valid or err pulse is suppressed.

Verification
REQ-033 Reset release: hold rst for 2 cycles, then release -> ready = 0 for 8 cycles, then 1; a read of addr 5 returns 4'h0 with rd_valid one cycle after acceptance.
REQ-034 Write/read: write 4'hA to addr 3, then read addr 3 on the next cycle -> rd_valid pulse with data_out = 4'hA; data_out holds 4'hA afterwards.
REQ-035 Out of range: set DEPTH = 6 and access addr 7 (read, then write 4'hF) -> err pulse after each, no rd_valid, data_out unchanged, all in-range contents unchanged.
REQ-036 Clear: fill addrs 0-7 with 4'h5, then assert clr for 1 cycle together with en -> the en is ignored, ready = 0 for 8 cycles, and a subsequent read of every address returns 4'h0.
REQ-037 Interruptions: assert clr at clear count 4 -> clear restarts and ready returns 8 cycles later. Assert rst during a read's acceptance cycle -> no rd_valid pulse, and data_out = 0.
